// File: rtl/l2_cache_nway.sv
// l2_cache_nway
//   Blocking, write-back, write-allocate L2 line cache that sits between L1 and
//   main memory. It is N-way set associative with tree-PLRU replacement.
//   Only one request is in flight at a time.
//
//   Optional feature: define L2_CACHE_FLUSH_EN to build the full-cache flush
//   engine. With the macro undefined, flush_req is ignored and flush_done is
//   tied low.
//
// Ports
//   clk, rst_n                       clock and asynchronous active-low reset
//   up_req_valid/ready/rw/addr/wline L1 request (rw=1 is a line writeback)
//   up_resp_valid/ready/rline        read response, held until accepted
//   mem_req_valid/ready/rw/addr/wline memory request, held until accepted
//   mem_resp_valid/ready/rline       refill data from memory
//   flush_req, flush_done            full flush request / completion pulse
//
// States
//   state        | meaning
//   IDLE         | waiting for a request (or flush)
//   LOOKUP       | tag compare on the latched request
//   HIT          | read: load response line; write: update line, set dirty
//   MISS_SEL     | choose victim (lowest invalid way, else PLRU)
//   WB_REQ       | write dirty victim back to memory
//   REFILL_REQ   | write miss: install line; read miss: request line
//   REFILL_WAIT  | wait for refill data
//   RESP         | hold response until L1 accepts
//   FLUSH_SCAN   | walk every entry, invalidating clean ones
//   FLUSH_WB     | write back a dirty entry found by the scan
module l2_cache_nway #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 32,
  parameter int SETS       = 16,
  parameter int WAYS       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      up_req_valid,
  output logic                      up_req_ready,
  input  logic                      up_req_rw,
  input  logic [ADDR_W-1:0]         up_req_addr,
  input  logic [LINE_BYTES*8-1:0]   up_req_wline,
  output logic                      up_resp_valid,
  input  logic                      up_resp_ready,
  output logic [LINE_BYTES*8-1:0]   up_resp_rline,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_rw,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic [LINE_BYTES*8-1:0]   mem_req_wline,
  input  logic                      mem_resp_valid,
  output logic                      mem_resp_ready,
  input  logic [LINE_BYTES*8-1:0]   mem_resp_rline,
  input  logic                      flush_req,
  output logic                      flush_done
);

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int OB     = $clog2(LINE_BYTES);
  localparam int IB     = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OB - IB;
  localparam int WW     = $clog2(WAYS);
  localparam int NB     = WAYS - 1;

`ifdef L2_CACHE_FLUSH_EN
  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_HIT, S_MISS_SEL, S_WB_REQ, S_REFILL_REQ,
    S_REFILL_WAIT, S_RESP, S_FLUSH_SCAN, S_FLUSH_WB
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_HIT, S_MISS_SEL, S_WB_REQ, S_REFILL_REQ,
    S_REFILL_WAIT, S_RESP
  } state_t;
`endif

  // Tree PLRU: node i has children 2i+1 / 2i+2, bit 0 means left subtree is LRU.
  // A touch makes every node on the path point away from the accessed way.
  function automatic logic [NB-1:0] plru_touch(input logic [NB-1:0] bits,
                                               input logic [WW-1:0] way);
    logic [NB-1:0] b;
    int node;
    b    = bits;
    node = 0;
    for (int l = 0; l < WW; l++) begin
      b[node] = ~way[WW-1-l];
      node    = 2 * node + 1 + int'(way[WW-1-l]);
    end
    return b;
  endfunction

  function automatic logic [WW-1:0] plru_victim(input logic [NB-1:0] bits);
    int node;
    node = 0;
    for (int l = 0; l < WW; l++)
      node = 2 * node + 1 + int'(bits[node]);
    return WW'(node - NB);
  endfunction

  state_t state_q, state_d;

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [NB-1:0]     plru_q  [SETS];

  logic              req_rw_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic [IB-1:0]     req_idx_q;
  logic [LINE_W-1:0] req_wline_q;
  logic [WW-1:0]     way_q;
  logic [LINE_W-1:0] resp_rline_q;

  logic [WAYS-1:0]   hit_vec;
  logic              hit_any;
  logic              any_inv;
  logic [WW-1:0]     hit_way;
  logic [WW-1:0]     inv_way;
  logic [WW-1:0]     victim_way;
  logic              victim_dirty;
  logic              accept;
  logic              wr_install;
  logic              rd_install;

  // Offset bits never matter for a line cache.
  logic unused_bits;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = 0; w < WAYS; w++)
      hit_vec[w] = valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q);
    // Descending walk so the lowest matching / invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WW'(w);
      if (!valid_q[req_idx_q][w]) begin
        inv_way = WW'(w);
        any_inv = 1'b1;
      end
    end
    hit_any      = |hit_vec;
    victim_way   = any_inv ? inv_way : plru_victim(plru_q[req_idx_q]);
    victim_dirty = dirty_q[req_idx_q][victim_way];
  end

  assign wr_install = (state_q == S_REFILL_REQ) && req_rw_q;
  assign rd_install = (state_q == S_REFILL_WAIT) && mem_resp_valid;
  assign up_resp_rline = resp_rline_q;

`ifdef L2_CACHE_FLUSH_EN
  logic [IB+WW-1:0] flush_cnt_q;
  logic [IB-1:0]    fl_set;
  logic [WW-1:0]    fl_way;
  logic             fl_last;
  logic             fl_dirty;
  logic             fl_clear;
  logic             flush_start;
  logic             flush_done_q;

  assign fl_set      = flush_cnt_q[IB+WW-1:WW];
  assign fl_way      = flush_cnt_q[WW-1:0];
  assign fl_last     = &flush_cnt_q;
  assign fl_dirty    = valid_q[fl_set][fl_way] & dirty_q[fl_set][fl_way];
  assign flush_start = (state_q == S_IDLE) && flush_req;
  // An entry is retired either directly (clean) or once its writeback is taken.
  assign fl_clear    = ((state_q == S_FLUSH_SCAN) && !fl_dirty) ||
                       ((state_q == S_FLUSH_WB) && mem_req_ready);
  assign flush_done  = flush_done_q;
  assign unused_bits = ^up_req_addr[OB-1:0];
`else
  assign flush_done  = 1'b0;
  assign unused_bits = ^{up_req_addr[OB-1:0], flush_req};
`endif

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    up_req_ready   = 1'b0;
    up_resp_valid  = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wline  = '0;
    mem_resp_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
`ifdef L2_CACHE_FLUSH_EN
        // A flush request wins over a same-cycle L1 request.
        up_req_ready = !flush_req;
        if (flush_req) begin
          state_d = S_FLUSH_SCAN;
        end else if (up_req_valid) begin
          accept  = 1'b1;
          state_d = S_LOOKUP;
        end
`else
        up_req_ready = 1'b1;
        if (up_req_valid) begin
          accept  = 1'b1;
          state_d = S_LOOKUP;
        end
`endif
      end
      S_LOOKUP:   state_d = hit_any ? S_HIT : S_MISS_SEL;
      S_HIT:      state_d = req_rw_q ? S_IDLE : S_RESP;
      S_MISS_SEL: state_d = victim_dirty ? S_WB_REQ : S_REFILL_REQ;
      S_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {tag_q[req_idx_q][way_q], req_idx_q, {OB{1'b0}}};
        mem_req_wline = data_q[req_idx_q][way_q];
        if (mem_req_ready) state_d = S_REFILL_REQ;
      end
      S_REFILL_REQ: begin
        if (req_rw_q) begin
          state_d = S_IDLE;
        end else begin
          mem_req_valid = 1'b1;
          mem_req_addr  = {req_tag_q, req_idx_q, {OB{1'b0}}};
          if (mem_req_ready) state_d = S_REFILL_WAIT;
        end
      end
      S_REFILL_WAIT: begin
        mem_resp_ready = 1'b1;
        if (mem_resp_valid) state_d = S_RESP;
      end
      S_RESP: begin
        up_resp_valid = 1'b1;
        if (up_resp_ready) state_d = S_IDLE;
      end
`ifdef L2_CACHE_FLUSH_EN
      S_FLUSH_SCAN: begin
        if (fl_dirty)     state_d = S_FLUSH_WB;
        else if (fl_last) state_d = S_IDLE;
      end
      S_FLUSH_WB: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {tag_q[fl_set][fl_way], fl_set, {OB{1'b0}}};
        mem_req_wline = data_q[fl_set][fl_way];
        if (mem_req_ready) state_d = fl_last ? S_IDLE : S_FLUSH_SCAN;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_rw_q     <= 1'b0;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      req_wline_q  <= '0;
      way_q        <= '0;
      resp_rline_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_rw_q    <= up_req_rw;
        req_tag_q   <= up_req_addr[ADDR_W-1:OB+IB];
        req_idx_q   <= up_req_addr[OB+IB-1:OB];
        req_wline_q <= up_req_wline;
      end
      if (state_q == S_LOOKUP)   way_q <= hit_way;
      if (state_q == S_MISS_SEL) way_q <= victim_way;
      if ((state_q == S_HIT) && !req_rw_q) resp_rline_q <= data_q[req_idx_q][way_q];
      if (rd_install) resp_rline_q <= mem_resp_rline;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (state_q == S_HIT) begin
        plru_q[req_idx_q] <= plru_touch(plru_q[req_idx_q], way_q);
        if (req_rw_q) dirty_q[req_idx_q][way_q] <= 1'b1;
      end
      if (wr_install || rd_install) begin
        valid_q[req_idx_q][way_q] <= 1'b1;
        dirty_q[req_idx_q][way_q] <= wr_install;
        plru_q[req_idx_q]         <= plru_touch(plru_q[req_idx_q], way_q);
      end
`ifdef L2_CACHE_FLUSH_EN
      if (flush_start) begin
        for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      end
      if (fl_clear) begin
        valid_q[fl_set][fl_way] <= 1'b0;
        dirty_q[fl_set][fl_way] <= 1'b0;
      end
`endif
    end
  end

  // Tag and data storage carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if ((state_q == S_HIT) && req_rw_q) data_q[req_idx_q][way_q] <= req_wline_q;
    if (wr_install) begin
      tag_q[req_idx_q][way_q]  <= req_tag_q;
      data_q[req_idx_q][way_q] <= req_wline_q;
    end
    if (rd_install) begin
      tag_q[req_idx_q][way_q]  <= req_tag_q;
      data_q[req_idx_q][way_q] <= mem_resp_rline;
    end
  end

`ifdef L2_CACHE_FLUSH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q  <= '0;
      flush_done_q <= 1'b0;
    end else begin
      if (flush_start)   flush_cnt_q <= '0;
      else if (fl_clear) flush_cnt_q <= flush_cnt_q + {{(IB+WW-1){1'b0}}, 1'b1};
      // Registered so the pulse lands in the first IDLE cycle after the scan.
      flush_done_q <= fl_clear && fl_last;
    end
  end
`endif

endmodule

// File: tb/tb_l2_cache_nway.sv
module tb_l2_cache_nway;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         up_req_valid, up_req_ready, up_req_rw;
  logic [31:0]  up_req_addr;
  logic [255:0] up_req_wline;
  logic         up_resp_valid, up_resp_ready;
  logic [255:0] up_resp_rline;
  logic         mem_req_valid, mem_req_ready, mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [255:0] mem_req_wline;
  logic         mem_resp_valid, mem_resp_ready;
  logic [255:0] mem_resp_rline;
  logic         flush_req, flush_done;

  int checks   = 0;
  int failures = 0;
  int fd_count = 0;
  logic mem_stall = 1'b0;

  typedef struct {
    logic         rw;
    logic [31:0]  addr;
    logic [255:0] wline;
  } mem_txn_t;
  mem_txn_t log_q[$];

  l2_cache_nway dut (
    .clk(clk), .rst_n(rst_n),
    .up_req_valid(up_req_valid), .up_req_ready(up_req_ready), .up_req_rw(up_req_rw),
    .up_req_addr(up_req_addr), .up_req_wline(up_req_wline),
    .up_resp_valid(up_resp_valid), .up_resp_ready(up_resp_ready), .up_resp_rline(up_resp_rline),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_wline(mem_req_wline),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rline(mem_resp_rline),
    .flush_req(flush_req), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mem_data(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_0000}};
  endfunction

  function automatic logic [255:0] wk(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(k);
    return {8{w}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: accepts any request one cycle after it appears (unless
  // stalled), logs it, and answers reads two cycles after acceptance.
  initial begin
    logic         hs_next, resp_hs_next, hs_rw;
    logic [31:0]  hs_addr, rd_addr;
    logic [255:0] hs_wline;
    int           rd_wait;
    mem_txn_t     t;
    hs_next = 1'b0; resp_hs_next = 1'b0; rd_wait = 0;
    hs_rw = 1'b0; hs_addr = '0; hs_wline = '0; rd_addr = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rline = '0;
    forever begin
      @(posedge clk); #1;
      if (hs_next) begin
        t.rw = hs_rw; t.addr = hs_addr; t.wline = hs_wline;
        log_q.push_back(t);
        if (!hs_rw) begin rd_wait = 2; rd_addr = hs_addr; end
      end
      if (resp_hs_next) mem_resp_valid = 1'b0;
      if (rd_wait > 0) begin
        rd_wait--;
        if (rd_wait == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rline = mem_data(rd_addr);
        end
      end
      mem_req_ready = mem_req_valid && !mem_stall;
      hs_next  = mem_req_valid && mem_req_ready;
      hs_rw    = mem_req_rw;
      hs_addr  = mem_req_addr;
      hs_wline = mem_req_wline;
      resp_hs_next = mem_resp_valid && mem_resp_ready;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (flush_done) fd_count++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic rw, input logic [31:0] a, input logic [255:0] wl);
    int n;
    up_req_rw = rw; up_req_addr = a; up_req_wline = wl; up_req_valid = 1'b1;
    n = 0;
    while (!up_req_ready && n < 400) begin @(posedge clk); #1; n++; end
    chk("accept_timeout", 256'(n < 400), 256'd1);
    @(posedge clk); #1;
    up_req_valid = 1'b0;
  endtask

  // Edges counted with the accept edge as edge 1.
  task automatic wait_resp(output logic [255:0] d, output int lat);
    lat = 1;
    while (!up_resp_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    chk("resp_timeout", 256'(lat < 300), 256'd1);
    d = up_resp_rline;
  endtask

  initial begin
    logic [255:0] d;
    int lat, base;
    up_req_valid = 0; up_req_rw = 0; up_req_addr = 0; up_req_wline = 0;
    up_resp_ready = 1; flush_req = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_up_req_ready", 256'(up_req_ready), 256'd1);
    chk("rst_up_resp_valid", 256'(up_resp_valid), 256'd0);
    chk("rst_up_resp_rline", up_resp_rline, 256'd0);
    chk("rst_mem_req_valid", 256'(mem_req_valid), 256'd0);
    chk("rst_mem_req_addr", 256'(mem_req_addr), 256'd0);
    chk("rst_mem_resp_ready", 256'(mem_resp_ready), 256'd0);
    chk("rst_flush_done", 256'(flush_done), 256'd0);
    rst_n = 1;
    @(posedge clk); #1;

    // 1: read miss then read hit of 0x0000
    issue(1'b0, 32'h0000, '0);
    wait_resp(d, lat);
    chk("t1_miss_data", d, mem_data(32'h0000));
    @(posedge clk); #1;
    chk("t1_mem_count", 256'(log_q.size()), 256'd1);
    chk("t1_mem_rw", 256'(log_q[0].rw), 256'd0);
    chk("t1_mem_addr", 256'(log_q[0].addr), 256'h0000);
    issue(1'b0, 32'h0000, '0);
    wait_resp(d, lat);
    chk("t1_hit_latency", 256'(lat), 256'd3);
    chk("t1_hit_data", d, mem_data(32'h0000));
    @(posedge clk); #1;
    chk("t1_hit_no_mem", 256'(log_q.size()), 256'd1);

    // 2: write miss 0x0200 then read it back
    issue(1'b1, 32'h0200, {8{32'hBBBB_0200}});
    issue(1'b0, 32'h0200, '0);
    wait_resp(d, lat);
    chk("t2_data", d, {8{32'hBBBB_0200}});
    chk("t2_latency", 256'(lat), 256'd3);
    @(posedge clk); #1;
    chk("t2_no_mem", 256'(log_q.size()), 256'd1);

    // 3/4: fill set 0 with dirty lines, miss on 0x1000 with memory stalled
    for (int k = 0; k < 8; k++) issue(1'b1, 32'(k * 32'h200), wk(k));
    repeat (4) @(posedge clk);
    #1;
    chk("t3_fill_no_mem", 256'(log_q.size()), 256'd1);
    mem_stall = 1'b1;
    issue(1'b0, 32'h1000, '0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_valid", 256'(mem_req_valid), 256'd1);
      chk("t4_stall_rw", 256'(mem_req_rw), 256'd1);
      chk("t4_stall_addr", 256'(mem_req_addr), 256'h0000);
      chk("t4_stall_wline", mem_req_wline, wk(0));
      chk("t4_stall_up_ready", 256'(up_req_ready), 256'd0);
      @(posedge clk); #1;
    end
    mem_stall = 1'b0;
    wait_resp(d, lat);
    chk("t3_refill_data", d, mem_data(32'h1000));
    @(posedge clk); #1;
    chk("t3_mem_count", 256'(log_q.size()), 256'd3);
    chk("t3_wb_rw", 256'(log_q[1].rw), 256'd1);
    chk("t3_wb_addr", 256'(log_q[1].addr), 256'h0000);
    chk("t3_wb_wline", log_q[1].wline, wk(0));
    chk("t3_rd_rw", 256'(log_q[2].rw), 256'd0);
    chk("t3_rd_addr", 256'(log_q[2].addr), 256'h1000);

    // 5: response back-pressure with a new request waiting
    up_resp_ready = 1'b0;
    issue(1'b0, 32'h1000, '0);
    wait_resp(d, lat);
    chk("t5_latency", 256'(lat), 256'd3);
    up_req_rw = 1'b0; up_req_addr = 32'h0200; up_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t5_hold_valid", 256'(up_resp_valid), 256'd1);
      chk("t5_hold_rline", up_resp_rline, mem_data(32'h1000));
      chk("t5_hold_up_ready", 256'(up_req_ready), 256'd0);
    end
    up_resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_ready_after_hs", 256'(up_req_ready), 256'd1);
    @(posedge clk); #1;
    up_req_valid = 1'b0;
    wait_resp(d, lat);
    chk("t5_next_data", d, wk(1));
    chk("t5_next_latency", 256'(lat), 256'd3);
    @(posedge clk); #1;
    chk("t5_no_mem", 256'(log_q.size()), 256'd3);

`ifdef L2_CACHE_FLUSH_EN
    // 6: flush writes back exactly the two dirty lines
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 32'h0000, '0);
    wait_resp(d, lat);
    chk("t6_clean_fill", d, mem_data(32'h0000));
    @(posedge clk); #1;
    issue(1'b1, 32'h0200, {8{32'hBBBB_0200}});
    issue(1'b1, 32'h0400, {8{32'hCCCC_0400}});
    repeat (4) @(posedge clk);
    #1;
    base = log_q.size();
    lat = fd_count;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    chk("t6_flush_up_ready", 256'(up_req_ready), 256'd0);
    begin
      int n;
      n = 0;
      while (!up_req_ready && n < 400) begin @(posedge clk); #1; n++; end
      chk("t6_flush_timeout", 256'(n < 400), 256'd1);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("t6_wb_count", 256'(log_q.size() - base), 256'd2);
    chk("t6_wb0_rw", 256'(log_q[base].rw), 256'd1);
    chk("t6_wb0_addr", 256'(log_q[base].addr), 256'h0200);
    chk("t6_wb0_wline", log_q[base].wline, {8{32'hBBBB_0200}});
    chk("t6_wb1_addr", 256'(log_q[base+1].addr), 256'h0400);
    chk("t6_wb1_wline", log_q[base+1].wline, {8{32'hCCCC_0400}});
    chk("t6_done_pulses", 256'(fd_count - lat), 256'd1);
    issue(1'b0, 32'h0000, '0);
    wait_resp(d, lat);
    chk("t6_post_data", d, mem_data(32'h0000));
    @(posedge clk); #1;
    chk("t6_post_miss_count", 256'(log_q.size() - base), 256'd3);
    chk("t6_post_miss_addr", 256'(log_q[base+2].addr), 256'h0000);
    chk("t6_post_miss_rw", 256'(log_q[base+2].rw), 256'd0);
`else
    // flush disabled: flush_req must be ignored
    flush_req = 1'b1;
    chk("nf_up_ready", 256'(up_req_ready), 256'd1);
    @(posedge clk); #1;
    flush_req = 1'b0;
    chk("nf_flush_done", 256'(flush_done), 256'd0);
    chk("nf_still_idle", 256'(up_req_ready), 256'd1);
    issue(1'b0, 32'h1000, '0);
    wait_resp(d, lat);
    chk("nf_hit_latency", 256'(lat), 256'd3);
    chk("nf_hit_data", d, mem_data(32'h1000));
    @(posedge clk); #1;
    chk("nf_no_mem", 256'(log_q.size()), 256'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
